tof_i2c_reg_master: RTL and testbench
=====================================

// Module: tof_i2c_reg_master
// PURPOSE
//  I2C master transaction engine serving the ToF sequencer's register-access requests to the VL53L5CX.
//  Takes one request (16-bit register address, write byte or read burst) and runs the full bus transaction.
//  Signals completion to the sequencer: a one-cycle ready pulse, plus read data and an error flag.
//  Sits between the ToF sequencer and the open-drain SCL/SDA pad buffers.
// PARAMETERS
//  CLK_HZ    100_000_000  system clock frequency
//  I2C_HZ    400_000      SCL frequency; QP = CLK_HZ/(4*I2C_HZ) clocks per quarter bit (min 2)
//  DEV_ADDR  7'h29        7-bit device address (wire bytes 0x52 write / 0x53 read)
// PORTS
//  clk               in   1   system clock
//  reset             in   1   synchronous, active-high
//  start             in   1   request valid; level, held by sequencer until ready
//  is_read           in   1   1 = read burst, 0 = single-byte write
//  register_address  in   16  register index, sent MSB byte first
//  i2c_data          in   8   write byte
//  nb_of_bytes       in   10  read length minus 1 (0 = one byte); ignored for writes
//  ready             out  1   one-cycle completion pulse
//  error             out  1   valid with ready; 1 = NACK seen, transaction aborted
//  i2c_data_in       out  16  last two bytes read, {older, newest}
//  busy              out  1   transaction in progress
//  scl_i / sda_i     in   1   synchronized pad inputs
//  scl_oe / sda_oe   out  1   1 = drive line low, 0 = release
// BEHAVIOUR
//  Clock/reset:
//  - One clock domain; reset is synchronous and active-high.
//  - Reset values: ready=0, error=0, busy=0, i2c_data_in=0, scl_oe=0, sda_oe=0, FSM=IDLE.
//  - Reset mid-transaction releases both lines on the next edge. No STOP is generated.
//  Request capture:
//  - In IDLE, start=1 latches is_read, register_address, i2c_data and nb_of_bytes.
//  - Sets busy=1 and enters START. Later input changes are ignored.
//  Bit timing:
//  - Each bit is 4 phases of QP clocks: SDA set while SCL low, SCL release, SCL high, SCL low.
//  - Clock stretching: after SCL is released, the phase counter holds while scl_i=0.
//  State sequence:
//  - IDLE -> START (SDA low while SCL high) -> DEV_W (0x52) -> ACK -> REG_HI -> ACK -> REG_LO -> ACK.
//  - Write: -> WR_DATA -> ACK -> STOP.
//  - Read: -> RESTART -> DEV_R (0x53) -> ACK -> RD_BYTE (repeated nb_of_bytes+1 times).
//  - After each RD_BYTE: master ACK (SDA low), except the final byte gets NACK (SDA released). Then STOP.
//  - STOP: SDA low, release SCL, release SDA. Then DONE.
//  - DONE: ready=1 for one cycle, busy=0, then WAIT_RELEASE.
//  - WAIT_RELEASE -> IDLE only when start=0. A start held high across ready never retriggers.
//  Read data:
//  - On each completed read byte b: i2c_data_in <= {i2c_data_in[7:0], b}.
//  - Burst counter is 10 bits and counts down; nb_of_bytes=1023 gives 1024 bytes, no wrap.
//  NACK handling:
//  - ACK slot: sample sda_i at the SCL-high midpoint. sda_i=1 means NACK.
//  - Any slave NACK (address, register or data byte) jumps straight to STOP.
//  - error=1 is asserted together with ready. error is cleared when the next request is captured.
//  Transaction latency in bits, each 4*QP clocks plus stretch:
//  - Write = 1+36+1 = 38 bits.
//  - Read = 1+27+1+9+9*(N+1)+1 bits, where N = nb_of_bytes.
//  Bus-line rules:
//  - SDA changes only while SCL is low, except in START/RESTART/STOP.
//  - Lines are only ever driven low (open drain).
// STRUCTURE
//  - Shared package tof_pkg: state enum i2c_state_t, DEV_ADDR default, RW bit constants, QP width function.
//  - Sub-module tof_i2c_bit_timer: QP counter, stretch hold, 2-bit phase output, phase_done strobe.
//  - Top level: transaction FSM, 8-bit shift register, bit counter, burst counter.
// TESTING
//  1. Write 0x7FFF<=0x00, slave ACKs all:
//     bus carries S,0x52,A,0x7F,A,0xFF,A,0x00,A,P; ready pulses once; error=0.
//  2. Read 0x0000 with nb_of_bytes=1, slave returns 0xF0,0x02:
//     S,0x52,0x00,0x00,Sr,0x53, then master ACK after byte 1 and NACK after byte 2;
//     i2c_data_in=0xF002.
//  3. Slave NACKs the device address:
//     STOP follows immediately; ready=1 and error=1; no register bytes appear on the bus.
//  4. Slave holds SCL low for 50 clocks during REG_LO bit 3:
//     bit timing resumes after release; total latency grows by exactly 50 cycles.
//  5. start held high for 20 cycles after ready:
//     no second transaction begins; a new start pulse after start=0 is accepted.
//  6. reset asserted mid-WR_DATA:
//     scl_oe=sda_oe=0 and busy=0 on the next edge; no ready pulse follows.

Source files
------------

// File: rtl/tof_pkg.sv
// tof_pkg: shared types and constants for the ToF I2C register master
package tof_pkg;
  typedef enum logic [3:0] {
    IDLE, START, DEV_W, ACK, REG_HI, REG_LO, WR_DATA, RESTART,
    DEV_R, RD_BYTE, MACK, STOP, DONE, WAIT_RELEASE
  } i2c_state_t;
  localparam logic [6:0] DEV_ADDR_DEF = 7'h29;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
  function automatic int qp_calc(input int clk_hz, input int i2c_hz);
    int q;
    q = clk_hz / (4 * i2c_hz);
    return (q < 2) ? 2 : q;
  endfunction
  function automatic int qp_width(input int qp);
    return $clog2(qp);
  endfunction
endpackage

// File: rtl/tof_i2c_bit_timer.sv
// tof_i2c_bit_timer: quarter-bit counter with clock-stretch hold and 2-bit phase
module tof_i2c_bit_timer import tof_pkg::*; #(
  parameter int QP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scl_oe,
  input  logic       scl_i,
  output logic [1:0] phase,
  output logic       phase_done
);
  localparam int W = qp_width(QP);
  logic [W-1:0] cnt;
  logic hold;
  // a released SCL still reading low means a slave is stretching the clock
  assign hold = !scl_oe && !scl_i;
  assign phase_done = en && !hold && (cnt == W'(QP - 1));
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      phase <= 2'd0;
    end else if (!hold) begin
      cnt <= phase_done ? '0 : cnt + 1'b1;
      phase <= phase + {1'b0, phase_done};
    end
  end
endmodule

// File: rtl/tof_i2c_reg_master.sv
// tof_i2c_reg_master: I2C transaction engine for 16-bit-addressed register writes and read bursts
module tof_i2c_reg_master import tof_pkg::*; #(
  parameter int CLK_HZ = 100_000_000,
  parameter int I2C_HZ = 400_000,
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_read,
  input  logic [15:0] register_address,
  input  logic [7:0]  i2c_data,
  input  logic [9:0]  nb_of_bytes,
  output logic        ready,
  output logic        error,
  output logic [15:0] i2c_data_in,
  output logic        busy,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe
);
  localparam int QP = qp_calc(CLK_HZ, I2C_HZ);
  i2c_state_t state, nxt, ret, after;
  logic [1:0] phase;
  logic phase_done, bit_done, sample, tx, tx_nxt, rd_req, ack_bit;
  logic [15:0] reg_addr;
  logic [7:0] wr_data, sr, load;
  logic [2:0] bit_cnt;
  logic [9:0] burst;

  tof_i2c_bit_timer #(.QP(QP)) u_timer (
    .clk(clk), .rst(reset), .en(busy), .scl_oe(scl_oe), .scl_i(scl_i),
    .phase(phase), .phase_done(phase_done)
  );

  assign bit_done = phase_done && (phase == 2'd3);
  assign sample = phase_done && (phase == 2'd1);
  assign tx = state inside {DEV_W, REG_HI, REG_LO, WR_DATA, DEV_R};
  assign tx_nxt = nxt inside {DEV_W, REG_HI, REG_LO, WR_DATA, DEV_R};

  always_ff @(posedge clk) state <= reset ? IDLE : nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:         if (start) nxt = START;
      START:        if (bit_done) nxt = DEV_W;
      DEV_W, REG_HI, REG_LO, WR_DATA, DEV_R:
                    if (bit_done && bit_cnt == 3'd7) nxt = ACK;
      ACK:          if (bit_done) nxt = ack_bit ? STOP : ret;
      RESTART:      if (bit_done) nxt = DEV_R;
      RD_BYTE:      if (bit_done && bit_cnt == 3'd7) nxt = MACK;
      MACK:         if (bit_done) nxt = (burst == 10'd0) ? STOP : RD_BYTE;
      STOP:         if (bit_done) nxt = DONE;
      DONE:         nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (!start) nxt = IDLE;
      default:      nxt = IDLE;
    endcase
    after = (state == DEV_W) ? REG_HI : (state == REG_HI) ? REG_LO :
            (state == REG_LO) ? (rd_req ? RESTART : WR_DATA) :
            (state == DEV_R) ? RD_BYTE : STOP;
    load = (nxt == DEV_W) ? {DEV_ADDR, RW_WRITE} : (nxt == REG_HI) ? reg_addr[15:8] :
           (nxt == REG_LO) ? reg_addr[7:0] : (nxt == WR_DATA) ? wr_data : {DEV_ADDR, RW_READ};
    busy = !(state inside {IDLE, DONE, WAIT_RELEASE});
    ready = (state == DONE);
    // START holds SCL released until SDA has fallen; STOP releases SDA last
    scl_oe = (state == START) ? (phase == 2'd3) : (state == STOP) ? (phase == 2'd0) :
             busy && (phase == 2'd0 || phase == 2'd3);
    sda_oe = (state inside {START, RESTART}) ? phase[1] : (state == STOP) ? (phase != 2'd3) :
             tx ? !sr[7] : (state == MACK) ? (burst != 10'd0) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_req <= 1'b0;
      reg_addr <= '0;
      wr_data <= '0;
      burst <= '0;
      sr <= '0;
      bit_cnt <= '0;
      ret <= IDLE;
      ack_bit <= 1'b0;
      error <= 1'b0;
      i2c_data_in <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_req <= is_read;
        reg_addr <= register_address;
        wr_data <= i2c_data;
        burst <= nb_of_bytes;
        error <= 1'b0;
      end
      bit_cnt <= (state != nxt) ? 3'd0 : bit_cnt + {2'b0, bit_done};
      if (state != nxt && tx_nxt) sr <= load;
      else if (tx && bit_done) sr <= {sr[6:0], 1'b0};
      else if (state == RD_BYTE && sample) sr <= {sr[6:0], sda_i};
      if (state != ACK && nxt == ACK) ret <= after;
      if (state == ACK && sample) ack_bit <= sda_i;
      if (state == ACK && bit_done && ack_bit) error <= 1'b1;
      if (state == RD_BYTE && bit_done && bit_cnt == 3'd7) i2c_data_in <= {i2c_data_in[7:0], sr};
      if (state == MACK && bit_done) burst <= burst - 10'd1;
    end
  end
endmodule

// File: tb/tb_tof_i2c_reg_master.sv
// tb_tof_i2c_reg_master: directed bench with an open-drain bus and a bit-level I2C slave model
module tb_tof_i2c_reg_master;
  logic clk = 1'b0;
  logic reset, start, is_read;
  logic [15:0] register_address;
  logic [7:0] i2c_data;
  logic [9:0] nb_of_bytes;
  logic ready, error, busy, scl_oe, sda_oe;
  logic [15:0] i2c_data_in;
  logic scl, sda, stretch, s_sda, nack_addr, slv_rst;
  logic pscl = 1'b1, psda = 1'b1, rd;
  logic [7:0] sh;
  logic [7:0] rdat [4];
  int bitn, byten, rdi, rdy_n, checks, failures, err_cap;
  int ev[$];
  int xp[$];

  localparam int S_EV = 32'h400, P_EV = 32'h800;

  assign scl = !(scl_oe || stretch);
  assign sda = !(sda_oe || s_sda);

  tof_i2c_reg_master #(.CLK_HZ(4_000_000), .I2C_HZ(250_000)) dut (
    .clk(clk), .reset(reset), .start(start), .is_read(is_read),
    .register_address(register_address), .i2c_data(i2c_data), .nb_of_bytes(nb_of_bytes),
    .ready(ready), .error(error), .i2c_data_in(i2c_data_in), .busy(busy),
    .scl_i(scl), .sda_i(sda), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // Slave: logs S/P and {ack,byte}, ACKs writes, serves rdat on reads, stops serving after a master NACK
  always @(negedge clk) begin
    if (slv_rst) begin
      ev.delete();
      rdy_n = 0; s_sda = 1'b0; bitn = 0; byten = 0; rdi = 0; rd = 1'b0; sh = 8'h00;
    end else begin
      if (ready) rdy_n++;
      if (pscl && scl && psda && !sda) begin
        ev.push_back(S_EV); bitn = 0; byten = 0; rd = 1'b0;
      end else if (pscl && scl && !psda && sda) begin
        ev.push_back(P_EV);
      end else if (!pscl && scl) begin
        if (bitn == 8) begin
          ev.push_back(int'({sda, sh}));
          if (byten != 0 && rd) rdi++;
          rd = (byten == 0) ? (sh[0] && !sda) : (rd && !sda);
          byten++; bitn = 0;
        end else begin
          sh = {sh[6:0], sda}; bitn++;
        end
      end else if (pscl && !scl) begin
        s_sda = (bitn == 8) ? ((!rd || byten == 0) && !(nack_addr && byten == 0))
                            : (rd && byten != 0 && !rdat[rdi & 3][7 - bitn]);
      end
    end
    pscl = scl;
    psda = sda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ev(input string tag);
    chk({tag, "_len"}, ev.size(), xp.size());
    for (int i = 0; i < xp.size(); i++) chk(tag, (i < ev.size()) ? ev[i] : -1, xp[i]);
  endtask

  task automatic clear();
    slv_rst = 1'b1;
    @(negedge clk);
    #1 slv_rst = 1'b0;
  endtask

  task automatic run(input logic r, input logic [15:0] a, input logic [7:0] d, input logic [9:0] nb,
                     output int lat);
    is_read = r; register_address = a; i2c_data = d; nb_of_bytes = nb; start = 1'b1; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      if (lat == 1) err_cap = error;
    end while (!ready && lat < 5000);
    if (!ready) lat = -1;
  endtask

  initial begin
    int lat, rel, g, bsy;
    logic p;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; is_read = 1'b0; register_address = '0; i2c_data = '0;
    nb_of_bytes = '0; stretch = 1'b0; nack_addr = 1'b0; slv_rst = 1'b1;
    rdat[0] = 8'hF0; rdat[1] = 8'h02; rdat[2] = 8'h55; rdat[3] = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0); chk("rst_error", error, 0); chk("rst_busy", busy, 0);
    chk("rst_data", i2c_data_in, 0); chk("rst_scl", scl_oe, 0); chk("rst_sda", sda_oe, 0);
    reset = 1'b0;
    clear();
    // 1: write 0x7FFF <= 0x00; 38 bits x 16 clocks
    run(1'b0, 16'h7FFF, 8'h00, 10'd0, lat);
    start = 1'b0;
    chk("wr_lat", lat, 609); chk("wr_err", error, 0);
    repeat (10) @(posedge clk);
    #1;
    xp = {S_EV, 32'h052, 32'h07F, 32'h0FF, 32'h000, P_EV};
    chk_ev("wr_bus"); chk("wr_ready_cnt", rdy_n, 1); chk("wr_idle", busy, 0);
    // 2: read two bytes from 0x0000; 57 bits
    clear();
    run(1'b1, 16'h0000, 8'h00, 10'd1, lat);
    start = 1'b0;
    chk("rd_lat", lat, 913); chk("rd_err", error, 0); chk("rd_data", i2c_data_in, 16'hF002);
    repeat (10) @(posedge clk);
    #1;
    xp = {S_EV, 32'h052, 32'h000, 32'h000, S_EV, 32'h053, 32'h0F0, 32'h102, P_EV};
    chk_ev("rd_bus");
    // 3: address NACK goes straight to STOP; 11 bits
    clear();
    nack_addr = 1'b1;
    run(1'b0, 16'h7FFF, 8'h00, 10'd0, lat);
    start = 1'b0;
    chk("nack_lat", lat, 177); chk("nack_err", error, 1);
    repeat (10) @(posedge clk);
    #1;
    nack_addr = 1'b0;
    xp = {S_EV, 32'h152, P_EV};
    chk_ev("nack_bus");
    // 4: 50-clock stretch in REG_LO bit index 3 (22nd bit after START)
    clear();
    fork
      run(1'b0, 16'h7FFF, 8'h00, 10'd0, lat);
      begin
        rel = 0; g = 0; p = 1'b0;
        while (rel < 21 && g < 5000) begin
          @(posedge clk); #2; g++;
          if (p && !scl_oe) rel++;
          p = scl_oe;
        end
        while (!scl_oe && g < 5000) begin @(posedge clk); #2; g++; end
        stretch = 1'b1;
        while (scl_oe && g < 5000) begin @(posedge clk); #2; g++; end
        repeat (50) @(posedge clk);
        #2 stretch = 1'b0;
      end
    join
    start = 1'b0;
    chk("str_err_cleared", err_cap, 0); chk("str_lat", lat, 659);
    repeat (10) @(posedge clk);
    #1;
    xp = {S_EV, 32'h052, 32'h07F, 32'h0FF, 32'h000, P_EV};
    chk_ev("str_bus");
    // 5: start held across ready must not retrigger
    clear();
    run(1'b0, 16'h0016, 8'h01, 10'd0, lat);
    chk("hold_lat", lat, 609);
    bsy = 0;
    repeat (20) begin @(posedge clk); #1; if (busy) bsy++; end
    chk("hold_no_busy", bsy, 0); chk("hold_no_bus", ev.size(), 6); chk("hold_one_ready", rdy_n, 1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("hold_new_busy", busy, 1);
    g = 0;
    while (!ready && g < 5000) begin @(posedge clk); #1; g++; end
    repeat (5) @(posedge clk);
    #1;
    chk("hold_second_ready", rdy_n, 2);
    // 6: reset during WR_DATA releases the bus at once, no ready follows
    clear();
    is_read = 1'b0; register_address = 16'h1234; i2c_data = 8'hA5; start = 1'b1;
    g = 0;
    while (ev.size() < 4 && g < 5000) begin @(posedge clk); #1; g++; end
    chk("rst6_reach", ev.size() >= 4, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("rst6_busy_before", busy, 1);
    reset = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    chk("rst6_scl", scl_oe, 0); chk("rst6_sda", sda_oe, 0); chk("rst6_busy", busy, 0);
    reset = 1'b0;
    clear();
    repeat (800) @(posedge clk);
    #1;
    chk("rst6_no_ready", rdy_n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
